// File: rtl/rf_sched_pkg.sv
// Shared widths and state type for the register file writeback scheduler.
package rf_sched_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    typedef enum logic {INIT, RUN} schedState_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, priority starting at ptr.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);
    logic [PW-1:0] idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owns the register file write port: zero sweep after reset, then round-robin
// writeback arbitration plus a busy scoreboard for read hazard detection.
module regfile_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [REG_W*NREQ-1:0]    req_reg,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    input  logic                     rsv_valid,
    input  logic [REG_W-1:0]         rsv_reg,
    input  logic [REG_W-1:0]         ReadReg1,
    input  logic [REG_W-1:0]         ReadReg2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     RegWrite,
    output logic [REG_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    output logic                     init_done
);
    localparam int PW = $clog2(NREQ);

    schedState_t       state;
    logic [REG_W-1:0]  cnt;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busyNext;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     nextPtr;
    logic [NREQ-1:0]   grant;
    logic [REG_W-1:0]  selReg;
    logic [DATA_W-1:0] selData;
    logic              running;

    assign running = (state == RUN);

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) arb (
        .req   (req_valid & {NREQ{running}}),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign hazard1   = running & busy[ReadReg1];
    assign hazard2   = running & busy[ReadReg2];

    always_comb begin
        selReg  = '0;
        selData = '0;
        nextPtr = ptr;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                selReg  = req_reg[REG_W*j +: REG_W];
                selData = req_data[DATA_W*j +: DATA_W];
                nextPtr = PW'((j + 1) % NREQ);
            end
        end
    end

    // Commit clears first so a same-edge reservation of that register wins.
    always_comb begin
        busyNext = busy;
        if (RegWrite)
            busyNext[WriteReg] = 1'b0;
        if (running && rsv_valid && (rsv_reg != '0))
            busyNext[rsv_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            cnt       <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            init_done <= 1'b0;
            busy      <= '0;
            ptr       <= '0;
        end else begin
            busy <= busyNext;
            case (state)
                INIT: begin
                    RegWrite  <= 1'b1;
                    WriteReg  <= cnt;
                    WriteData <= '0;
                    cnt       <= cnt + 1'b1;
                    if (cnt == REG_W'(NREGS - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    // Register 0 requests are accepted but never reach the file.
                    RegWrite <= (|grant) && (selReg != '0);
                    if (|grant) begin
                        WriteReg  <= selReg;
                        WriteData <= selData;
                        ptr       <= nextPtr;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed plus randomized bench for regfile_wb_scheduler against a behavioural model.
module tb_regfile_wb_scheduler;
    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [5*NREQ-1:0]    req_reg;
    logic [32*NREQ-1:0]   req_data;
    logic                 rsv_valid;
    logic [4:0]           rsv_reg;
    logic [4:0]           ReadReg1;
    logic [4:0]           ReadReg2;
    logic                 hazard1;
    logic                 hazard2;
    logic                 RegWrite;
    logic [4:0]           WriteReg;
    logic [31:0]          WriteData;
    logic                 init_done;

    int testCount = 0;
    int failCount = 0;

    logic [31:0] mBusy;
    logic        expRegWrite;
    logic [4:0]  expWriteReg;
    logic [31:0] expWriteData;
    int          lastGrant;
    int          gIdx;

    logic [NREQ-1:0]    pend;
    logic [5*NREQ-1:0]  pReg;
    logic [32*NREQ-1:0] pData;

    regfile_wb_scheduler #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One RUN cycle: drive, check against the model, then advance the model past the edge.
    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [5*NREQ-1:0] regs,
                                 input logic [32*NREQ-1:0] datas, input logic rv,
                                 input logic [4:0] rr, input logic [4:0] r1, input logic [4:0] r2);
        logic [NREQ-1:0] expGrant;
        logic [4:0]      gReg;
        req_valid = v;
        req_reg   = regs;
        req_data  = datas;
        rsv_valid = rv;
        rsv_reg   = rr;
        ReadReg1  = r1;
        ReadReg2  = r2;
        #1;
        gIdx = -1;
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (lastGrant + 1 + i) % NREQ;
            if (v[c] && gIdx < 0) gIdx = c;
        end
        expGrant = '0;
        if (gIdx >= 0) expGrant[gIdx] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(expGrant));
        checkOutput("hazard1", 32'(hazard1), 32'(mBusy[r1]));
        checkOutput("hazard2", 32'(hazard2), 32'(mBusy[r2]));
        checkOutput("RegWrite", 32'(RegWrite), 32'(expRegWrite));
        if (expRegWrite) begin
            checkOutput("WriteReg", 32'(WriteReg), 32'(expWriteReg));
            checkOutput("WriteData", WriteData, expWriteData);
        end
        @(posedge clk);
        if (expRegWrite) mBusy[expWriteReg] = 1'b0;
        if (rv && rr != 5'd0) mBusy[rr] = 1'b1;
        if (gIdx >= 0) begin
            gReg         = regs[5*gIdx +: 5];
            lastGrant    = gIdx;
            expRegWrite  = (gReg != 5'd0);
            expWriteReg  = gReg;
            expWriteData = datas[32*gIdx +: 32];
        end else begin
            expRegWrite = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic resetModel();
        mBusy        = '0;
        expRegWrite  = 1'b1;
        expWriteReg  = 5'd31;
        expWriteData = '0;
        lastGrant    = NREQ - 1;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '1;
        req_reg   = '0;
        req_data  = '0;
        rsv_valid = 1'b1;
        rsv_reg   = 5'd9;
        ReadReg1  = 5'd9;
        ReadReg2  = 5'd0;
        pend      = '0;
        pReg      = '0;
        pData     = '0;
        #1;
        checkOutput("rst_RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("rst_WriteReg", 32'(WriteReg), 32'd0);
        checkOutput("rst_WriteData", WriteData, 32'd0);
        checkOutput("rst_init_done", 32'(init_done), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checkOutput("sweep_RegWrite", 32'(RegWrite), 32'd1);
            checkOutput("sweep_WriteReg", 32'(WriteReg), 32'(k - 1));
            checkOutput("sweep_WriteData", WriteData, 32'd0);
            checkOutput("sweep_init_done", 32'(init_done), (k == 32) ? 32'd1 : 32'd0);
            checkOutput("sweep_ready", 32'(req_ready), 32'd0);
            checkOutput("sweep_hazard1", 32'(hazard1), 32'd0);
            if (k == 31) begin
                req_valid = '0;
                rsv_valid = 1'b0;
            end
        end
        resetModel();

        for (int n = 0; n < 4; n++)
            applyStimulus(2'b11, {5'd4, 5'd3}, {32'h4444_0000, 32'h3333_0000}, 1'b0, 5'd0, 5'd9, 5'd3);
        applyStimulus(2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, 1'b0, 5'd0, 5'd5, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd5, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd5, 5'd0);

        applyStimulus(2'b00, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(2'b10, {5'd7, 5'd0}, {32'h0000_0077, 32'd0}, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        applyStimulus(2'b01, {5'd0, 5'd7}, {32'd0, 32'h0000_0707}, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(2'b01, {5'd0, 5'd7}, {32'd0, 32'h0000_7777}, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);

        applyStimulus(2'b01, {5'd0, 5'd0}, {32'd0, 32'h0000_1234}, 1'b1, 5'd0, 5'd0, 5'd0);
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);

        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 9) < 6)) begin
                    pend[i]          = 1'b1;
                    pReg[5*i +: 5]   = 5'($urandom_range(0, 7));
                    pData[32*i +: 32] = $urandom;
                end
            end
            applyStimulus(pend, pReg, pData, ($urandom_range(0, 9) < 3),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (gIdx >= 0) pend[gIdx] = 1'b0;
        end

        req_valid = '0;
        rsv_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("rst2_hazard1", 32'(hazard1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) @(posedge clk);
        #1;
        checkOutput("mid_WriteReg", 32'(WriteReg), 32'd9);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("mid_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("restart_RegWrite", 32'(RegWrite), 32'd1);
            checkOutput("restart_WriteReg", 32'(WriteReg), 32'(k - 1));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sole owner of the register file write port (RegWrite, WriteReg, WriteData).
- After reset, sequences a zero-initialisation sweep of all 32 registers.
- Then shares the write port round-robin between NREQ writeback requesters using valid/ready.
- Keeps a busy scoreboard of reserved destinations and flags read hazards for the two register file read ports.

Parameters:
- NREQ, 2, number of writeback requesters (2..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  requester i's write accepted this cycle.
- req_reg  in  5*NREQ  destination of requester i, slice [5i+4:5i].
- req_data  in  32*NREQ  data of requester i, slice [32i+31:32i].
- rsv_valid  in  1  reserve destination rsv_reg (instruction issued, result outstanding).
- rsv_reg  in  5  destination to reserve.
- ReadReg1  in  5  read port 1 address (shared with register file).
- ReadReg2  in  5  read port 2 address.
- hazard1  out  1  ReadReg1 is busy.
- hazard2  out  1  ReadReg2 is busy.
- RegWrite  out  1  register file write enable (registered).
- WriteReg  out  5  register file write address (registered).
- WriteData  out  32  register file write data (registered).
- init_done  out  1  sweep complete, port in RUN.

Behaviour:
- Reset (rst=0, async):
  - state=INIT, cnt=0, RegWrite=0, WriteReg=0, WriteData=0, init_done=0.
  - busy[31:0]=0; rr pointer set so requester 0 has top priority.
  - Applies at any time, including mid-sweep or mid-grant. Pending handshakes are dropped and the sweep restarts.
- INIT:
  - On edge k (k=1..32 after rst release), load RegWrite=1, WriteReg=k-1, WriteData=0.
  - At edge 32, state moves to RUN and init_done goes to 1.
  - During INIT: req_ready=0, rsv_valid ignored.
- RUN arbitration:
  - Combinational grant among asserted req_valid bits.
  - Priority starts at (last granted + 1) mod NREQ.
  - req_ready = one-hot grant, and is 0 when no request is pending.
  - The pointer updates only on a grant.
  - Requesters must hold valid/reg/data stable until ready. The scheduler does not buffer.
- Write output timing:
  - A grant in cycle t loads RegWrite=1, WriteReg, WriteData at the end of t.
  - The register file commits at the end of t+1. Latency is 1 cycle from handshake to output.
  - With no grant, RegWrite=0; WriteReg and WriteData hold their previous values.
- Register 0:
  - A request to reg 0 is accepted (ready=1) but loads RegWrite=0.
  - Reg 0 is written only by the INIT sweep.
- Scoreboard:
  - rsv_valid sets busy[rsv_reg] at the clock edge. Reserving reg 0 is ignored.
  - busy[r] clears on the edge where RegWrite=1 and WriteReg=r (the register file commit edge).
  - If a set and a clear hit the same reg on the same edge, set wins.
  - Double reservation is legal; busy stays 1 and clears on the first commit.
- Hazards:
  - hazard1 = busy[ReadReg1], hazard2 = busy[ReadReg2]. Both are combinational.
  - Both are always 0 for reg 0 and during INIT.
- Throughput:
  - One write per cycle.
  - With all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.

Decomposition:
- Package rf_sched_pkg:
  - REG_W=5, DATA_W=32, NREGS=32.
  - State enum {INIT, RUN}.
- Sub-module rr_arbiter:
  - Inputs: parameter NREQ, req vector, pointer.
  - Outputs: one-hot grant.
  - Pure combinational, reusable.
- Top holds:
  - sweep counter;
  - output register;
  - scoreboard;
  - pointer.

Test Plan:
- Init sweep:
  - Stimulus: release rst, hold req_valid=0.
  - Required: 32 consecutive cycles of RegWrite=1, WriteReg=0..31, WriteData=0. init_done rises after edge 32. req_ready stays 0 throughout.
- Single write:
  - Stimulus: after init, req_valid=01, req0 reg=5, data=0xDEADBEEF.
  - Required: req_ready=01 that cycle. Next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF. The cycle after, RegWrite=0.
- Round-robin:
  - Stimulus: both requesters held valid, reg 3 and reg 4, for 4 cycles.
  - Required: grants 0,1,0,1. Outputs alternate WriteReg 3,4,3,4 with one-cycle lag.
- Scoreboard:
  - Stimulus: rsv reg 7; ReadReg1=7.
  - Required: hazard1=1 from the next cycle. It stays 1 until the RegWrite=1/WriteReg=7 cycle, then reads 0 after that edge.
  - Stimulus: same-edge rsv 7 plus commit 7.
  - Required: hazard1 stays 1.
- Reg 0:
  - Stimulus: request reg 0 data 0x1234; rsv reg 0; ReadReg2=0.
  - Required: ready=1, next-cycle RegWrite=0, hazard2=0.
- Reset mid-sweep:
  - Stimulus: assert rst at sweep step 10.
  - Required: RegWrite=0 and init_done=0 immediately (async). The sweep restarts from WriteReg=0 after release.
